alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_div.sv | 64 ++++++
 rtl/alu_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM definitions for the sequential ALU controller.
// The divider path is only built when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_MUL = 3'b011,
        OP_DIV = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider, one quotient bit per cycle.
// Instantiated by alu_seq_ctrl only when ALU_SEQ_DIV_EN is defined.
module alu_seq_div #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  b_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [W:0]    sh;
    logic [W:0]    diff;
    logic          ge;

    // Partial remainder stays below b, so bit W of diff is a clean sign.
    always_comb begin
        sh    = {rem_q, quo_q[W-1]};
        diff  = sh - {1'b0, b_q};
        ge    = ~diff[W];
        rem_d = ge ? diff[W-1:0] : sh[W-1:0];
        quo_d = {quo_q[W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= a;
            b_q    <= b;
            cnt_q  <= CW'(W);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CW'(1);
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: AND/OR/ADD/MUL in EXEC, iterative DIV.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise op 100 is illegal.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           err
);

    state_e         state_q, state_d;
    op_e            op_q;
    logic [W-1:0]   a_q, b_q;
    logic [2*W-1:0] result_q, result_d;
    logic           err_q, err_d;
    logic [2*W-1:0] calc_res;
    logic           calc_err;
    logic           accept;
    logic           div_go;
    logic           div_done;
    logic [2*W-1:0] div_res;

    assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_DIV_EN
    logic [W-1:0] div_quo, div_rem;

    assign div_go  = accept && (op == OP_DIV) && (b != '0);
    assign div_res = {div_rem, div_quo};

    alu_seq_div #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_go),
        .a         (a),
        .b         (b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign div_go   = 1'b0;
    assign div_done = 1'b0;
    assign div_res  = '0;
`endif

    always_comb begin
        calc_res = '0;
        calc_err = 1'b0;
        case (op_q)
            OP_AND: calc_res = {{W{1'b0}}, a_q & b_q};
            OP_OR:  calc_res = {{W{1'b0}}, a_q | b_q};
            OP_ADD: calc_res = {{(W-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
            OP_MUL: calc_res = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
`ifdef ALU_SEQ_DIV_EN
            // Only a zero divisor reaches EXEC with a DIV opcode.
            OP_DIV: begin
                calc_res = {a_q, {W{1'b1}}};
                calc_err = 1'b1;
            end
`endif
            default: calc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = div_go ? ST_DIV : ST_EXEC;
            end
            ST_EXEC: begin
                state_d  = ST_DONE;
                result_d = calc_res;
                err_d    = calc_err;
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d  = ST_DONE;
                    result_d = div_res;
                    err_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            if (accept) begin
                op_q <= op_e'(op);
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl at W=2.
// Expectations follow ALU_SEQ_DIV_EN the same way as the design.
module tb_alu_seq_ctrl;

    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           err;

    typedef struct {
        logic [3:0] res;
        logic       err;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_ov = 1'b0;

    alu_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: pops on the first DONE cycle of each result.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", int'(result), int'(e.res));
                check("err", int'(err), int'(e.err));
                check("latency", cyc - e.t0, e.lat);
            end
        end
        prev_ov = out_valid;
    end

    function automatic logic [4:0] model(input logic [2:0] o,
                                         input logic [1:0] x,
                                         input logic [1:0] y);
        int ix, iy;
        ix = int'(x);
        iy = int'(y);
        case (o)
            3'd0: return {1'b0, 4'(ix & iy)};
            3'd1: return {1'b0, 4'(ix | iy)};
            3'd2: return {1'b0, 4'(ix + iy)};
            3'd3: return {1'b0, 4'(ix * iy)};
`ifdef ALU_SEQ_DIV_EN
            3'd4: begin
                if (iy == 0) return {1'b1, 4'(ix * 4 + 3)};
                return {1'b0, 4'((ix % iy) * 4 + ix / iy)};
            end
`endif
            default: return 5'b10000;
        endcase
    endfunction

    task automatic drive(input logic [2:0] o, input logic [1:0] x,
                         input logic [1:0] y, input bit push,
                         input logic [3:0] res, input logic e,
                         input int lat);
        exp_t ent;
        @(negedge clk);
        check("in_ready_before_cmd", int'(in_ready), 1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        ent.res = res;
        ent.err = e;
        ent.lat = lat;
        ent.t0 = cyc;
        if (push) sb.push_back(ent);
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom);
        a = 2'($urandom);
        b = 2'($urandom);
    endtask

    task automatic run(input logic [2:0] o, input logic [1:0] x,
                       input logic [1:0] y, input logic [3:0] res,
                       input logic e, input int lat, input int hold);
        bit seen;
        drive(o, x, y, 1'b1, res, e, lat);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("timeout_out_valid", 0, 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            op = 3'($urandom);
            a = 2'($urandom);
            b = 2'($urandom);
            @(negedge clk);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_result", int'(result), int'(res));
            check("hold_err", int'(err), int'(e));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        logic [4:0] m;
        logic [2:0] ro;
        logic [1:0] ra, rb;
        int         rl;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_err", int'(err), 0);

        run(3'd2, 2'd3, 2'd3, 4'b0110, 1'b0, 2, 0);
        run(3'd0, 2'd3, 2'd2, 4'b0010, 1'b0, 2, 0);
        run(3'd1, 2'd1, 2'd2, 4'b0011, 1'b0, 2, 0);
        run(3'd3, 2'd3, 2'd3, 4'b1001, 1'b0, 2, 5);
        run(3'd7, 2'd3, 2'd1, 4'b0000, 1'b1, 2, 0);
        run(3'd5, 2'd2, 2'd2, 4'b0000, 1'b1, 2, 0);
`ifdef ALU_SEQ_DIV_EN
        run(3'd4, 2'd3, 2'd2, 4'b0101, 1'b0, 4, 0);
        run(3'd4, 2'd2, 2'd0, 4'b1011, 1'b1, 2, 0);
        run(3'd4, 2'd3, 2'd1, 4'b0011, 1'b0, 4, 2);
`else
        run(3'd4, 2'd3, 2'd1, 4'b0000, 1'b1, 2, 0);
        run(3'd4, 2'd2, 2'd0, 4'b0000, 1'b1, 2, 0);
`endif

        drive(3'd4, 2'd3, 2'd2, 1'b0, 4'b0, 1'b0, 0);
`ifdef ALU_SEQ_DIV_EN
        @(negedge clk);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_result", int'(result), 0);
        check("midrst_err", int'(err), 0);
        repeat (6) @(negedge clk);
        check("midrst_quiet", int'(out_valid), 0);

`ifdef ALU_SEQ_DIV_EN
        run(3'd4, 2'd2, 2'd1, 4'b0010, 1'b0, 4, 0);
`else
        run(3'd4, 2'd2, 2'd1, 4'b0000, 1'b1, 2, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 2'($urandom);
            rb = 2'($urandom);
            m = model(ro, ra, rb);
            rl = 2;
`ifdef ALU_SEQ_DIV_EN
            if (ro == 3'd4 && rb != 2'd0) rl = W + 2;
`endif
            run(ro, ra, rb, m[3:0], m[4], rl, i % 3);
        end

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
